// File: rtl/pipe_fft_dly_rw_ctrl.sv
// rtl/pipe_fft_dly_rw_ctrl.sv - read/write sequencer for the pipelined-FFT 8x66 delay RAM
// Optional sticky queue under/overflow flag dly_err enabled by `define PIPEFFT_DLY_ERR_EN.
module pipe_fft_dly_rw_ctrl #(
  parameter int W      = 66,
  parameter int AW     = 3,
  parameter int DLY    = 8,
  parameter int RD_LAT = 2
) (
  input  logic          clk,
  input  logic          nGrst,
  input  logic          rst,
  input  logic          ce,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          dout_vld,
  output logic [W-1:0]  ram_wD,
  output logic [AW-1:0] ram_wAddr,
  output logic          ram_wEn,
  output logic [AW-1:0] ram_rAddr,
  input  logic [W-1:0]  ram_rD
`ifdef PIPEFFT_DLY_ERR_EN
  ,
  output logic          dly_err
`endif
);

  localparam int QD  = RD_LAT + 1;
  localparam int QCW = $clog2(QD + 1);
  localparam int FW  = $clog2(DLY + 1);
  localparam int AVW = AW + 2;
  localparam int ICW = $clog2(RD_LAT + 1);
  localparam int CW  = $clog2(2 * QD + 2);

  if (DLY < RD_LAT + 3 || DLY > (1 << AW)) begin : g_bad_dly
    $error("pipe_fft_dly_rw_ctrl: DLY out of legal range");
  end

  logic [AW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [AVW-1:0]    avail_q, avail_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [RD_LAT-1:0] iss_q, iss_d;
  logic [W-1:0]      qm_q [QD];
  logic [W-1:0]      qm_d [QD];
  logic [QCW-1:0]    qcnt_q, qcnt_d;
  logic [W-1:0]      dout_q, dout_d;
  logic              vld_q, vld_d;
`ifdef PIPEFFT_DLY_ERR_EN
  logic              err_q, err_d;
`endif

  logic [ICW-1:0] inflight;
  logic           pop, pop_ok, push, issue;
  logic [QCW-1:0] cnt_mid;

  assign ram_wEn   = ce;
  assign ram_wD    = din;
  assign ram_wAddr = wp_q;
  assign ram_rAddr = rp_q;
  assign dout      = dout_q;
  assign dout_vld  = vld_q;
`ifdef PIPEFFT_DLY_ERR_EN
  assign dly_err   = err_q;
`endif

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + ICW'(iss_q[i]);
    end
    pop    = ce && (fill_q == FW'(DLY));
    pop_ok = pop && (qcnt_q != '0);
    push   = iss_q[RD_LAT-1];
    // A same-cycle pop frees a slot, so credit counts it; otherwise
    // back-to-back strobes would leave the queue empty at every pop.
    issue  = (avail_q >= AVW'(2)) &&
             ((CW'(qcnt_q) + CW'(inflight)) < (CW'(QD) + CW'(pop)));

    wp_d    = wp_q + AW'(ce);
    rp_d    = rp_q + AW'(issue);
    avail_d = avail_q + AVW'(ce) - AVW'(issue);
    fill_d  = (ce && (fill_q < FW'(DLY))) ? fill_q + FW'(1) : fill_q;

    iss_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) begin
      iss_d[i] = iss_q[i-1];
    end

    qm_d   = qm_q;
    dout_d = dout_q;
    vld_d  = vld_q;
    cnt_mid = qcnt_q;
    if (pop_ok) begin
      dout_d = qm_q[0];
      vld_d  = 1'b1;
      for (int i = 0; i < QD - 1; i++) begin
        qm_d[i] = qm_q[i+1];
      end
      cnt_mid = qcnt_q - QCW'(1);
    end
    qcnt_d = cnt_mid;
    if (push && (cnt_mid < QCW'(QD))) begin
      for (int i = 0; i < QD; i++) begin
        if (QCW'(i) == cnt_mid) qm_d[i] = ram_rD;
      end
      qcnt_d = cnt_mid + QCW'(1);
    end

`ifdef PIPEFFT_DLY_ERR_EN
    err_d = err_q || (pop && (qcnt_q == '0)) ||
            (push && (cnt_mid == QCW'(QD)));
`endif

    if (rst) begin
      wp_d    = '0;
      rp_d    = '0;
      avail_d = '0;
      fill_d  = '0;
      iss_d   = '0;
      qcnt_d  = '0;
      dout_d  = '0;
      vld_d   = 1'b0;
      for (int i = 0; i < QD; i++) begin
        qm_d[i] = '0;
      end
`ifdef PIPEFFT_DLY_ERR_EN
      err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      avail_q <= '0;
      fill_q  <= '0;
      iss_q   <= '0;
      qcnt_q  <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
      for (int i = 0; i < QD; i++) begin
        qm_q[i] <= '0;
      end
`ifdef PIPEFFT_DLY_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      avail_q <= avail_d;
      fill_q  <= fill_d;
      iss_q   <= iss_d;
      qcnt_q  <= qcnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      for (int i = 0; i < QD; i++) begin
        qm_q[i] <= qm_d[i];
      end
`ifdef PIPEFFT_DLY_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_pipe_fft_dly_rw_ctrl.sv
// tb/tb_pipe_fft_dly_rw_ctrl.sv - self-checking bench for pipe_fft_dly_rw_ctrl
module tb_pipe_fft_dly_rw_ctrl;
  localparam int W = 66, AW = 3, DLY = 8, RD_LAT = 2;

  logic          clk = 1'b0;
  logic          nGrst, rst, ce;
  logic [W-1:0]  din, dout, ram_wD, ram_rD;
  logic          dout_vld, ram_wEn;
  logic [AW-1:0] ram_wAddr, ram_rAddr;
`ifdef PIPEFFT_DLY_ERR_EN
  logic          dly_err;
`endif

  always #5 clk = ~clk;

  pipe_fft_dly_rw_ctrl #(.W(W), .AW(AW), .DLY(DLY), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .nGrst(nGrst), .rst(rst), .ce(ce), .din(din),
    .dout(dout), .dout_vld(dout_vld), .ram_wD(ram_wD), .ram_wAddr(ram_wAddr),
    .ram_wEn(ram_wEn), .ram_rAddr(ram_rAddr), .ram_rD(ram_rD)
`ifdef PIPEFFT_DLY_ERR_EN
    , .dly_err(dly_err)
`endif
  );

  // RAM model: registered read address, registered read data
  logic [W-1:0]  mem [1 << AW];
  logic [AW-1:0] raddr_q;
  logic [W-1:0]  rdata_q;
  always @(posedge clk) begin
    if (ram_wEn) mem[ram_wAddr] <= ram_wD;
    raddr_q <= ram_rAddr;
    rdata_q <= mem[raddr_q];
  end
  assign ram_rD = rdata_q;

  int errors = 0;
  int checks = 0;

  // Reference: expected output is the input history DLY strobes back
  logic [W-1:0] hist [1024];
  int           nstrobe;
  logic [W-1:0] exp_dout;
  logic         exp_vld;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    nstrobe  = 0;
    exp_dout = '0;
    exp_vld  = 1'b0;
  endtask

  task automatic check_outputs();
    chk("dout_vld", W'(dout_vld), W'(exp_vld));
    chk("dout", dout, exp_dout);
    chk("ram_wAddr", W'(ram_wAddr), W'(nstrobe % (1 << AW)));
`ifdef PIPEFFT_DLY_ERR_EN
    chk("dly_err", W'(dly_err), '0);
`endif
  endtask

  task automatic cyc(input logic c, input logic [W-1:0] d, input logic r);
    ce  = c;
    din = d;
    rst = r;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (c) begin
      hist[nstrobe] = d;
      if (nstrobe >= DLY) begin
        exp_dout = hist[nstrobe - DLY];
        exp_vld  = 1'b1;
      end
      nstrobe++;
    end
    #1;
    check_outputs();
  endtask

  function automatic logic [W-1:0] rnd();
    logic [95:0] v;
    v = {$urandom(), $urandom(), $urandom()};
    return v[W-1:0];
  endfunction

  initial begin
    nGrst = 1'b0; rst = 1'b0; ce = 1'b0; din = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    chk("reset_rAddr", W'(ram_rAddr), '0);
    nGrst = 1'b1;

    // continuous strobes, incrementing data
    for (int i = 0; i < 20; i++) cyc(1'b1, W'(i), 1'b0);
    cyc(1'b0, '0, 1'b0);

    // restart and run with random gaps
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 60; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      cyc(1'b1, W'(100 + i), 1'b0);
      for (int g = 0; g < gap; g++) cyc(1'b0, rnd(), 1'b0);
    end

    // continuous random data across pointer wrap
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 40; i++) cyc(1'b1, rnd(), 1'b0);

    // synchronous restart while reads are in flight
    cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) cyc(1'b1, rnd(), 1'b0);
    cyc(1'b1, rnd(), 1'b1);
    chk("rst_dout", dout, '0);
    chk("rst_vld", W'(dout_vld), '0);
    for (int i = 0; i < 20; i++) cyc(1'b1, rnd(), 1'b0);

    // asynchronous reset between edges
    for (int i = 0; i < 10; i++) cyc(1'b1, rnd(), 1'b0);
    #2;
    nGrst = 1'b0;
    #1;
    model_reset();
    chk("async_dout", dout, '0);
    chk("async_vld", W'(dout_vld), '0);
    chk("async_wAddr", W'(ram_wAddr), '0);
    chk("async_rAddr", W'(ram_rAddr), '0);
    @(negedge clk);
    nGrst = 1'b1;
    for (int i = 0; i < 30; i++) cyc(($urandom_range(0, 3) != 0), rnd(), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
